wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among three writeback sources: A = ALU, B = load, C = multiply/divide unit.
- Arbitrates among them and drives a one-hot source select, plus a registered write address, data and write-enable to the register file.
- Sits at the end of the pipeline's writeback stage. It replaces ad-hoc source selection with a valid/ready handshake and a starvation guard.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register index.
- STARVE_MAX, 4, consecutive lost arbitration cycles after which a requester is promoted to top priority (range 1..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  source A has a write pending.
- a_addr  input  ADDR_W  source A destination register.
- a_data  input  DATA_W  source A write data.
- a_ready  output  1  source A granted this cycle.
- b_valid / b_addr / b_data / b_ready  same as A, for source B.
- c_valid / c_addr / c_data / c_ready  same as A, for source C.
- wb_sel  output  3  one-hot granted source, registered: 001 = A, 010 = B, 100 = C, 000 = idle.
- wb_we  output  1  register-file write enable, registered.
- wb_addr  output  ADDR_W  registered write address.
- wb_data  output  DATA_W  registered write data.
- busy  output  1  combinational: at least one valid is high and not granted this cycle.

Behaviour:
- Reset (sync, active-high): wb_sel = 000, wb_we = 0, wb_addr = 0, wb_data = 0, all starvation counters = 0.
- Reset (cont.): all *_ready = 0 while rst = 1. Requests pending at reset are dropped, not granted later; each source must re-present them.
- Handshake: each source holds valid, addr and data stable until it sees ready = 1. Transfer occurs in a cycle where valid and ready are both 1. ready is combinational from the valids and counters.
- At most one ready per cycle. ready is never high without the matching valid.
- Default priority: A > B > C.
- Starvation counter per source (4 bit, saturating at STARVE_MAX):
  - increments each cycle its valid = 1 and it is not granted;
  - clears on grant or when its valid = 0.
- A source whose counter == STARVE_MAX is "starved". Any starved source beats every non-starved source. Among several starved sources, the lowest index wins (A, then B, then C).
- Latency: a grant in cycle N appears on wb_* at the edge ending cycle N, i.e. visible in cycle N+1.
  - wb_sel = one-hot of the granted source.
  - wb_addr and wb_data = the granted source's addr and data.
  - wb_we = 1 unless the granted addr == 0.
- Writes to register 0 are granted (ready = 1) but produce wb_we = 0, with wb_sel still one-hot. The register-0 discard is handled here.
- Idle cycle (no valid): next wb_sel = 000, wb_we = 0; wb_addr and wb_data hold their previous values.
- Back-to-back grants: sustained throughput is one write per cycle, with no bubble between grants.
- A valid dropped before its grant: the source's counter clears; no error is flagged.
- busy is derived only from current inputs and counters; it is never registered.

Test Plan:
- Reset then idle: after rst, wb_sel = 000, wb_we = 0, wb_addr = 0, wb_data = 0; all ready = 0 during rst.
- A alone, addr = 5, data = 0x1234 -> a_ready = 1 in the same cycle; next cycle wb_sel = 001, wb_we = 1, wb_addr = 5, wb_data = 0x1234.
- A, B, C all valid each cycle with A re-presenting new data every cycle, STARVE_MAX = 4:
  - A granted cycles 0-3;
  - B and C counters reach 4 in cycle 4;
  - B granted cycle 4 (wb_sel = 010 in cycle 5);
  - C granted cycle 5 (C's counter is 4 while B is granted, so C, starved, beats A).
- C valid with addr = 0, data = 0xFFFF_FFFF -> c_ready = 1; next cycle wb_sel = 100, wb_we = 0.
- B valid, A asserted for 2 cycles, then reset asserted in cycle 2 while B is still pending -> b_ready = 0 during rst; B's counter = 0 after rst; wb_sel = 000.
- Alternating single requests A, C, B on consecutive cycles -> wb_sel sequence 001, 100, 010 with no idle cycle between them.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the single register-file write port among three
//            writeback sources (A = ALU, B = load, C = mul/div) using a
//            valid/ready handshake. Fixed priority A > B > C, with a
//            per-source starvation guard. A source that has lost STARVE_MAX
//            consecutive cycles outranks every non-starved source.
// Ports    : clk, rst (synchronous, active-high)
//            {a,b,c}_valid/_addr/_data  in  : pending write from each source
//            {a,b,c}_ready              out : grant (combinational)
//            wb_sel  out : registered one-hot granted source (000 = idle)
//            wb_we   out : registered write enable (0 for register 0)
//            wb_addr out : registered write address
//            wb_data out : registered write data
//            busy    out : combinational, some valid is high but not granted
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              c_valid,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_data,
    output logic              c_ready,
    output logic [2:0]        wb_sel,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [3:0]        r_cnt [3];
    logic [2:0]        w_valid;
    logic [2:0]        w_starved;
    logic [2:0]        w_pick;
    logic [2:0]        w_grant;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_valid = {c_valid, b_valid, a_valid};

    // Starved sources form their own tier; within whichever tier is active
    // the lowest index wins, which isolating the lowest set bit gives us.
    always_comb begin
        w_starved = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_starved[i] = w_valid[i] && (r_cnt[i] == c_starve_max);
        end
        w_pick  = (|w_starved) ? w_starved : w_valid;
        w_grant = rst ? 3'b000 : (w_pick & (3'(~w_pick) + 3'd1));
    end

    assign a_ready = w_grant[0];
    assign b_ready = w_grant[1];
    assign c_ready = w_grant[2];
    assign busy    = |(w_valid & ~w_grant);

    always_comb begin
        w_addr = a_addr;
        w_data = a_data;
        case (w_grant)
            3'b010: begin
                w_addr = b_addr;
                w_data = b_data;
            end
            3'b100: begin
                w_addr = c_addr;
                w_data = c_data;
            end
            default: begin
                w_addr = a_addr;
                w_data = a_data;
            end
        endcase
    end

    // Counters clear on grant or when the source withdraws; otherwise they
    // count lost cycles and saturate at the starvation threshold.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst || !w_valid[i] || w_grant[i]) begin
                r_cnt[i] <= 4'd0;
            end else if (r_cnt[i] < c_starve_max) begin
                r_cnt[i] <= r_cnt[i] + 4'd1;
            end
        end
    end

    // Address/data hold across idle cycles; only select and enable drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_sel  <= 3'b000;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (|w_grant) begin
            wb_sel  <= w_grant;
            wb_we   <= (w_addr != '0);
            wb_addr <= w_addr;
            wb_data <= w_data;
        end else begin
            wb_sel  <= 3'b000;
            wb_we   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Self-checking bench for wb_port_arbiter. Directed scenarios
//            followed by randomized traffic, all compared against a
//            behavioural model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    v;
    logic [AW-1:0] ad [3];
    logic [DW-1:0] dt [3];
    logic          a_ready, b_ready, c_ready;
    logic [2:0]    wb_sel;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          busy;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .a_valid(v[0]), .a_addr(ad[0]), .a_data(dt[0]), .a_ready(a_ready),
        .b_valid(v[1]), .b_addr(ad[1]), .b_data(dt[1]), .b_ready(b_ready),
        .c_valid(v[2]), .c_addr(ad[2]), .c_data(dt[2]), .c_ready(c_ready),
        .wb_sel(wb_sel), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy)
    );

    int            vectors = 0;
    int            errors  = 0;

    // Behavioural model state
    int            m_lost [3];
    logic [2:0]    m_rdy;
    logic [2:0]    e_sel;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner: first starved source in A,B,C order, else first valid one.
    function automatic int winner();
        int w = -1;
        for (int i = 0; i < 3; i++)
            if (w < 0 && v[i] && m_lost[i] >= SM) w = i;
        for (int i = 0; i < 3; i++)
            if (w < 0 && v[i]) w = i;
        return w;
    endfunction

    // One clock cycle: inputs are already applied; check the grant, take the
    // edge, advance the model, and check the registered outputs.
    task automatic cycle();
        int w;
        #1;
        w = winner();
        m_rdy = (rst || w < 0) ? 3'b000 : 3'(1 << w);
        check("ready", {61'd0, c_ready, b_ready, a_ready}, {61'd0, m_rdy});
        check("busy", {63'd0, busy}, {63'd0, |(v & ~m_rdy)});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) m_lost[i] = 0;
            e_sel = 3'b000; e_we = 1'b0; e_addr = '0; e_data = '0;
        end else begin
            for (int i = 0; i < 3; i++)
                m_lost[i] = (v[i] && !m_rdy[i]) ? m_lost[i] + 1 : 0;
            if (w >= 0) begin
                e_sel  = m_rdy;
                e_we   = (ad[w] != 0);
                e_addr = ad[w];
                e_data = dt[w];
            end else begin
                e_sel = 3'b000;
                e_we  = 1'b0;
            end
        end
        #1;
        check("wb_sel", {61'd0, wb_sel}, {61'd0, e_sel});
        check("wb_we", {63'd0, wb_we}, {63'd0, e_we});
        check("wb_addr", {59'd0, wb_addr}, {59'd0, e_addr});
        check("wb_data", {32'd0, wb_data}, {32'd0, e_data});
    endtask

    task automatic req(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        v[s] = 1'b1; ad[s] = a; dt[s] = d;
    endtask

    initial begin
        rst = 1'b1;
        v   = 3'b000;
        for (int i = 0; i < 3; i++) begin ad[i] = '0; dt[i] = '0; m_lost[i] = 0; end
        e_sel = 3'b000; e_we = 1'b0; e_addr = '0; e_data = '0; m_rdy = 3'b000;

        // Reset, including requests present during reset (never granted).
        @(posedge clk); #1;
        cycle();
        req(0, 5'd3, 32'h11); req(1, 5'd4, 32'h22); req(2, 5'd6, 32'h33);
        cycle();
        check("reset_sel", {61'd0, wb_sel}, 64'd0);
        check("reset_we", {63'd0, wb_we}, 64'd0);
        rst = 1'b0; v = 3'b000;
        cycle();

        // A alone.
        req(0, 5'd5, 32'h1234);
        cycle();
        check("a_alone_sel", {61'd0, wb_sel}, 64'b001);
        check("a_alone_data", {32'd0, wb_data}, 64'h1234);
        v = 3'b000;
        cycle();  // idle: addr/data hold

        // All three valid, A re-presenting every cycle: starvation promotion.
        req(0, 5'd1, 32'hA0); req(1, 5'd2, 32'hB0); req(2, 5'd3, 32'hC0);
        for (int k = 0; k < 7; k++) begin
            cycle();
            if (k == 4) check("starve_b_sel", {61'd0, wb_sel}, 64'b010);
            if (k == 5) check("starve_c_sel", {61'd0, wb_sel}, 64'b100);
            for (int i = 1; i < 3; i++) if (m_rdy[i]) v[i] = 1'b0;
            dt[0] = dt[0] + 32'd1;
        end
        v = 3'b000;

        // Register 0 write from C: granted but no write enable.
        req(2, 5'd0, 32'hFFFF_FFFF);
        cycle();
        check("r0_sel", {61'd0, wb_sel}, 64'b100);
        check("r0_we", {63'd0, wb_we}, 64'd0);
        v = 3'b000;

        // B pending behind A, then reset while B is still pending.
        req(1, 5'd7, 32'hBEEF); req(0, 5'd8, 32'h1);
        cycle();
        dt[0] = 32'h2;
        cycle();
        rst = 1'b1; v[0] = 1'b0;
        cycle();
        rst = 1'b0;
        req(0, 5'd9, 32'h3);
        cycle();  // A must beat B: B's lost-cycle count was cleared
        v[0] = 1'b0;
        cycle();
        v = 3'b000;

        // Alternating A, C, B back-to-back.
        req(0, 5'd10, 32'hAA); cycle(); v = 3'b000;
        check("alt_a", {61'd0, wb_sel}, 64'b001);
        req(2, 5'd11, 32'hCC); cycle(); v = 3'b000;
        check("alt_c", {61'd0, wb_sel}, 64'b100);
        req(1, 5'd12, 32'hBB); cycle(); v = 3'b000;
        check("alt_b", {61'd0, wb_sel}, 64'b010);

        // Randomized traffic honouring the handshake.
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 60) == 0);
            cycle();
            for (int i = 0; i < 3; i++) begin
                if (rst || m_rdy[i] || !v[i]) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    ad[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                    dt[i] = $urandom;
                end else if ($urandom_range(0, 15) == 0) begin
                    v[i] = 1'b0;  // withdrawn before grant
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
